open_list_head_reader: RTL and testbench
========================================

// Module: open_list_head_reader
// PURPOSE
//  Read-side consumer of the parallel open-list queues. It keeps one prefetched head node per queue.
//  Each cycle it picks the global minimum-f head and hands it to the node-expansion stage over valid/ready.
//  It sits between the open-list queue array and the expander, and issues all queue pops.
// PARAMETERS
//  NUM_QUEUES    8  number of open-list queues served
//  RETRY_CYCLES  4  backoff cycles after an empty pop response, min 1
// PORTS
//  clk           in   1                      clock
//  rst           in   1                      reset, asynchronous, active-high
//  q_pop         out  NUM_QUEUES             one-cycle pop request per queue
//  q_valid       in   NUM_QUEUES             pop response strobe, valid the cycle after q_pop
//  q_node        in   NUM_QUEUES x node_array_t  popped node per queue
//  out_valid     out  1                      out_node/out_qid valid
//  out_ready     in   1                      expander accepts
//  out_node      out  node_array_t           min-f node
//  out_qid       out  $clog2(NUM_QUEUES)     source queue of out_node
//  all_empty     out  1                      every queue reported empty, no node held
// BEHAVIOUR
//  - Reset (async): all lanes EMPTY, out_valid=0, out_node=0, out_qid=0, dry=all 1, counters=0.
//    q_pop is forced 0 while rst=1.
//  - Each lane has a 4-state FSM:
//    EMPTY -> PENDING: q_pop[i]=1 for this one cycle (q_pop[i] == state EMPTY && !rst).
//    PENDING: samples q_valid[i].
//      1 -> FULL, capture q_node[i], clear dry[i].
//      0 -> BACKOFF, cnt=RETRY_CYCLES-1, set dry[i].
//    BACKOFF: cnt decrements; at cnt==0 -> EMPTY. An empty queue is re-polled every RETRY_CYCLES+2 cycles.
//    FULL: holds the head until it is selected -> EMPTY.
//  - At most one outstanding pop per lane. A lane never pops while FULL or PENDING.
//  - Selection (combinational) is over FULL lanes: minimum node.f, compared unsigned.
//    On a tie, the lowest lane index wins.
//  - Output register: load when any lane is FULL and (!out_valid || out_ready).
//    On load, out_node/out_qid take the winner, out_valid=1, and the winner lane goes to EMPTY on the same edge.
//  - out_valid drops only on (out_valid && out_ready) with no FULL lane.
//    out_node/out_qid stay stable while out_valid && !out_ready.
//  - Accept and reload in the same cycle is allowed: full throughput of 1 node/cycle when heads are available.
//  - Latency: q_pop at cycle N, q_valid at N+1, lane FULL at N+2, out_valid visible at N+3.
//  - all_empty = &dry && !out_valid && no lane FULL/PENDING; driven from registers only.
//  - Reset mid-operation: a held out_node and captured heads are discarded.
//    Polling restarts at the first cycle after rst deasserts.
// CONFIGURATION
//  OPEN_LIST_HEAD_READER_STATS_EN defined adds these outputs:
//    stat_pops [31:0]      q_pop pulses
//    stat_empty [31:0]     empty responses
//    stat_dispatch [31:0]  out handshakes
//  All three saturate at 2^32-1 and reset to 0.
//  Undefined: the ports and counters are absent, and the behaviour is otherwise identical.
// STRUCTURE
//  Shared package open_list_pkg holds:
//    - lane_state_t enum {EMPTY, PENDING, FULL, BACKOFF}
//    - QID_W localparam function
//    - node_array_t, shared node type (field f)
//  Sub-module open_list_head_lane: one per queue, holds the FSM, backoff counter, head register and dry flag.
//  The top module holds the min-f tree, output register, all_empty and stats.
// TESTING
//  1. After reset, q0 answers f=10, q1 answers f=5, others empty -> out f=5 qid=1 at N+3, then f=10 qid=0 next cycle (out_ready=1).
//  2. q2 and q5 both f=7 -> qid=2 first, then qid=5; no pop on q5 until its head is dispatched.
//  3. out_ready=0 for 10 cycles with all lanes FULL -> out_node stable, zero q_pop pulses; release gives back-to-back dispatch.
//  4. All queues empty -> each q_pop repeats every 6 cycles (RETRY_CYCLES=4), all_empty=1 from the first full poll round.
//  5. rst pulsed while out_valid=1 and lanes FULL -> out_valid=0 and q_pop=0 immediately; first q_pop on the first cycle after release.
//  6. STATS_EN: 3 dispatches, 2 empty polls -> stat_dispatch=3, stat_empty=2, stat_pops=5.

Source files
------------

// File: rtl/open_list_pkg.sv
// Shared types for the open-list read side: lane FSM states, the node record
// and the queue-id width helper.
package open_list_pkg;

  localparam int F_W   = 16;
  localparam int TAG_W = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2,
    BACKOFF = 2'd3
  } lane_state_t;

  typedef struct packed {
    logic [F_W-1:0]   f;
    logic [TAG_W-1:0] tag;
  } node_array_t;

  function automatic int qid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/open_list_head_lane.sv
// One open-list queue lane: pop/response FSM with empty-queue backoff,
// the prefetched head node and the per-queue dry flag.
module open_list_head_lane
  import open_list_pkg::*;
#(
  parameter int RETRY_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pop,
  input  logic        rsp_valid,
  input  node_array_t rsp_node,
  input  logic        take,
  output logic        full,
  output logic        pending,
  output logic        dry,
  output node_array_t head
);

  localparam int CNT_W = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;

  lane_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dry_q, dry_d;
  logic             capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      dry_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dry_q   <= dry_d;
    end
  end

  // Head payload is only meaningful while FULL, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) head <= rsp_node;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dry_d   = dry_q;
    capture = 1'b0;
    unique case (state_q)
      EMPTY:   state_d = PENDING;
      PENDING: begin
        if (rsp_valid) begin
          state_d = FULL;
          capture = 1'b1;
          dry_d   = 1'b0;
        end else begin
          state_d = BACKOFF;
          cnt_d   = CNT_W'(RETRY_CYCLES - 1);
          dry_d   = 1'b1;
        end
      end
      BACKOFF: begin
        if (cnt_q == '0) state_d = EMPTY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FULL:    if (take) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign pop     = (state_q == EMPTY) && !rst;
  assign full    = (state_q == FULL);
  assign pending = (state_q == PENDING);
  assign dry     = dry_q;

endmodule

// File: rtl/open_list_head_reader.sv
// Open-list head reader: prefetches one head per queue and streams the global
// minimum-f node to the expander. Define OPEN_LIST_HEAD_READER_STATS_EN for
// the saturating pop/empty/dispatch statistics outputs.
module open_list_head_reader
  import open_list_pkg::*;
#(
  parameter  int NUM_QUEUES   = 8,
  parameter  int RETRY_CYCLES = 4,
  localparam int QID_W        = qid_w(NUM_QUEUES)
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic        [NUM_QUEUES-1:0]   q_pop,
  input  logic        [NUM_QUEUES-1:0]   q_valid,
  input  node_array_t [NUM_QUEUES-1:0]   q_node,
  output logic                           out_valid,
  input  logic                           out_ready,
  output node_array_t                    out_node,
  output logic        [QID_W-1:0]        out_qid,
  output logic                           all_empty
`ifdef OPEN_LIST_HEAD_READER_STATS_EN
  ,
  output logic        [31:0]             stat_pops,
  output logic        [31:0]             stat_empty,
  output logic        [31:0]             stat_dispatch
`endif
);

  logic [NUM_QUEUES-1:0] full, pending, dry, take;
  node_array_t           head [NUM_QUEUES];

  logic                  any_full_p0;
  logic [QID_W-1:0]      win_qid_p0;
  logic [F_W-1:0]        win_f_p0;
  logic                  load_p0;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_lane
    open_list_head_lane #(
      .RETRY_CYCLES(RETRY_CYCLES)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pop      (q_pop[i]),
      .rsp_valid(q_valid[i]),
      .rsp_node (q_node[i]),
      .take     (take[i]),
      .full     (full[i]),
      .pending  (pending[i]),
      .dry      (dry[i]),
      .head     (head[i])
    );
    assign take[i] = load_p0 && (win_qid_p0 == QID_W'(i));
  end

  // Stage p0: pick the minimum-f FULL head; strict compare keeps the lowest index on ties.
  always_comb begin
    any_full_p0 = 1'b0;
    win_qid_p0  = '0;
    win_f_p0    = '1;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (full[i] && (!any_full_p0 || (head[i].f < win_f_p0))) begin
        any_full_p0 = 1'b1;
        win_qid_p0  = QID_W'(i);
        win_f_p0    = head[i].f;
      end
    end
  end

  assign load_p0 = any_full_p0 && (!out_valid || out_ready);

  // Stage p1: output register toward the expander.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_node  <= '0;
      out_qid   <= '0;
    end else if (load_p0) begin
      out_valid <= 1'b1;
      out_node  <= head[win_qid_p0];
      out_qid   <= win_qid_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign all_empty = (&dry) && !out_valid && !(|full) && !(|pending);

`ifdef OPEN_LIST_HEAD_READER_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pops     <= '0;
      stat_empty    <= '0;
      stat_dispatch <= '0;
    end else begin
      stat_pops     <= sat_add(stat_pops, 32'($countones(q_pop)));
      stat_empty    <= sat_add(stat_empty, 32'($countones(pending & ~q_valid)));
      stat_dispatch <= sat_add(stat_dispatch, {31'd0, out_valid && out_ready});
    end
  end
`endif

endmodule

// File: tb/tb_open_list_head_reader.sv
// Bench for open_list_head_reader: behavioural queue responder, timestamp-based
// reference model of polling/selection, and a dispatch scoreboard.
module tb_open_list_head_reader;
  import open_list_pkg::*;

  localparam int NQ    = 8;
  localparam int RETRY = 4;
  localparam int QW    = qid_w(NQ);
  localparam int INF   = 1 << 30;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic        [NQ-1:0]    q_pop;
  logic        [NQ-1:0]    q_valid = '0;
  node_array_t [NQ-1:0]    q_node  = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  node_array_t             out_node;
  logic        [QW-1:0]    out_qid;
  logic                    all_empty;
`ifdef OPEN_LIST_HEAD_READER_STATS_EN
  logic [31:0] stat_pops, stat_empty, stat_dispatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  open_list_head_reader #(.NUM_QUEUES(NQ), .RETRY_CYCLES(RETRY)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_pop    (q_pop),
    .q_valid  (q_valid),
    .q_node   (q_node),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_node (out_node),
    .out_qid  (out_qid),
    .all_empty(all_empty)
`ifdef OPEN_LIST_HEAD_READER_STATS_EN
    ,
    .stat_pops    (stat_pops),
    .stat_empty   (stat_empty),
    .stat_dispatch(stat_dispatch)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue contents handed out by the responder
  node_array_t tq [NQ][$];
  logic [NQ-1:0] pop_seen = '0;
  int tag_ctr = 0;

  task automatic push_node(input int q, input int f);
    node_array_t n;
    n.f   = F_W'(f);
    n.tag = TAG_W'(tag_ctr);
    tag_ctr++;
    tq[q].push_back(n);
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NQ; i++) if (tq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) pop_seen = q_pop;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NQ; i++) begin
      if (pop_seen[i] && tq[i].size() > 0) begin
        q_valid[i] = 1'b1;
        q_node[i]  = tq[i].pop_front();
      end else begin
        q_valid[i] = 1'b0;
        q_node[i]  = '0;
      end
    end
  end

  // Reference model: lanes described by the cycle of their next poll
  typedef struct { node_array_t n; int q; } disp_t;
  disp_t exp_q[$];
  disp_t log_q[$];

  int          cyc = 0;
  logic [NQ-1:0] held = '0, pend = '0, dry_m = '1, exp_pop;
  node_array_t held_n [NQ];
  int          next_poll [NQ];
  logic        ov_m = 1'b0;
  node_array_t on_m = '0;
  int          oq_m = 0;
  int          n_pops = 0, n_empty = 0, n_disp = 0;
  int          w;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_q_pop", 64'(q_pop), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_node", 64'(out_node), 64'(0));
      chk("rst_all_empty", 64'(all_empty), 64'(1));
      held = '0; pend = '0; dry_m = '1; ov_m = 1'b0;
      foreach (next_poll[i]) next_poll[i] = cyc + 1;
      exp_q.delete();
      n_pops = 0; n_empty = 0; n_disp = 0;
    end else begin
      for (int i = 0; i < NQ; i++) exp_pop[i] = (next_poll[i] == cyc);
      chk("q_pop", 64'(q_pop), 64'(exp_pop));
      chk("out_valid", 64'(out_valid), 64'(ov_m));
      if (ov_m) begin
        chk("out_node", 64'(out_node), 64'(on_m));
        chk("out_qid", 64'(out_qid), 64'(oq_m));
      end
      chk("all_empty", 64'(all_empty), 64'((&dry_m) && !ov_m && held == '0 && pend == '0));
      if (ov_m && out_ready) n_disp++;
      if (held != '0 && (!ov_m || out_ready)) begin
        w = -1;
        for (int i = 0; i < NQ; i++)
          if (held[i] && (w < 0 || held_n[i].f < held_n[w].f)) w = i;
        ov_m = 1'b1; on_m = held_n[w]; oq_m = w;
        held[w] = 1'b0; next_poll[w] = cyc + 1;
        exp_q.push_back('{held_n[w], w});
      end else if (ov_m && out_ready) begin
        ov_m = 1'b0;
      end
      for (int i = 0; i < NQ; i++) begin
        if (pend[i]) begin
          if (q_valid[i]) begin
            held[i] = 1'b1; held_n[i] = q_node[i]; dry_m[i] = 1'b0;
          end else begin
            dry_m[i] = 1'b1; next_poll[i] = cyc + RETRY + 1; n_empty++;
          end
        end
        pend[i] = exp_pop[i];
        if (exp_pop[i]) begin
          next_poll[i] = INF;
          n_pops++;
        end
      end
    end
  end

  // Monitor: each DUT handshake consumes the oldest expected dispatch
  always @(negedge clk) begin
    disp_t e, d;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("disp_unexpected", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("disp_node", 64'(out_node), 64'(e.n));
        chk("disp_qid", 64'(out_qid), 64'(e.q));
      end
      d.n = out_node; d.q = int'(out_qid);
      log_q.push_back(d);
    end
  end

  int  cnt_a, cnt_b;
  bit  drained;

  initial begin
    // Scenario 1: q0 f=10, q1 f=5 preloaded before reset release
    push_node(0, 10);
    push_node(1, 5);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("s1_count", 64'(log_q.size()), 64'(2));
    if (log_q.size() >= 2) begin
      chk("s1_first_qid", 64'(log_q[0].q), 64'(1));
      chk("s1_first_f", 64'(log_q[0].n.f), 64'(5));
      chk("s1_second_qid", 64'(log_q[1].q), 64'(0));
      chk("s1_second_f", 64'(log_q[1].n.f), 64'(10));
    end
    log_q.delete();

    // Scenario 2: equal f on q2 and q5
    push_node(2, 7);
    push_node(5, 7);
    repeat (15) @(posedge clk);
    #1;
    chk("s2_count", 64'(log_q.size()), 64'(2));
    if (log_q.size() >= 2) begin
      chk("s2_first_qid", 64'(log_q[0].q), 64'(2));
      chk("s2_second_qid", 64'(log_q[1].q), 64'(5));
    end

    // Scenario 3: stall with every lane FULL, then release
    out_ready = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      push_node(i, $urandom_range(0, 99));
      push_node(i, $urandom_range(0, 99));
    end
    repeat (16) @(posedge clk);
    cnt_a = 0;
    repeat (10) begin
      @(negedge clk);
      cnt_a += $countones(q_pop);
    end
    chk("s3_stall_pops", 64'(cnt_a), 64'(0));
    chk("s3_stall_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #1 out_ready = 1'b1;
    cnt_b = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid && out_ready) cnt_b++;
    end
    chk("s3_back_to_back", 64'(cnt_b), 64'(8));
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (8) @(posedge clk);

    // Scenario 5: reset while holding output and heads
    #1 rst = 1'b1;
    for (int i = 0; i < NQ; i++) tq[i].delete();
    #1;
    chk("s5_rst_out_valid", 64'(out_valid), 64'(0));
    chk("s5_rst_q_pop", 64'(q_pop), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("s5_first_pop", 64'(q_pop), 64'({NQ{1'b1}}));

    // Scenario 4: all queues empty, polling cadence and all_empty
    cnt_a = 0; cnt_b = 0;
    repeat (18) begin
      @(negedge clk);
      if (q_pop[3]) cnt_a++;
      if (all_empty) cnt_b++;
    end
    chk("s4_poll_count", 64'(cnt_a), 64'(3));
    chk("s4_all_empty_cycles", 64'(cnt_b), 64'(15));

    // Scenario 6: random traffic and backpressure
    for (int k = 0; k < 1500; k++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) push_node($urandom_range(0, NQ - 1), $urandom_range(0, 31));
    end
    out_ready = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      if (queues_empty() && exp_q.size() == 0 && !ov_m && held == '0 && pend == '0) begin
        drained = 1'b1;
        break;
      end
    end
    chk("drain_complete", 64'(drained), 64'(1));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
`ifdef OPEN_LIST_HEAD_READER_STATS_EN
    chk("stat_pops", 64'(stat_pops), 64'(n_pops));
    chk("stat_empty", 64'(stat_empty), 64'(n_empty));
    chk("stat_dispatch", 64'(stat_dispatch), 64'(n_disp));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
